// File: rtl/chacha20_poly1305_pkg.sv
// ============================================================================
// Package  : chacha20_poly1305_pkg
// Purpose  : Shared types and constants for the ChaCha20-Poly1305 AEAD core.
//            Holds the tag-verifier state encoding, tag geometry constants and
//            a helper that selects one 32-bit word out of a 128-bit tag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chacha20_poly1305_pkg;

  localparam int TAG_WORDS = 4;
  localparam int TAG_BITS  = 128;
  localparam int WORD_BITS = 32;

  // Tag verifier FSM encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    VS_IDLE     = 2'd0,
    VS_WAIT_TAG = 2'd1,
    VS_COMPARE  = 2'd2,
    VS_DONE     = 2'd3
  } verify_state_t;

  // Word 0 is the most significant word of the tag: word i -> tag[127-32*i -: 32]
  function automatic logic [WORD_BITS-1:0] tag_word(
    input logic [TAG_BITS-1:0] tag,
    input logic [1:0]          idx
  );
    return tag[TAG_BITS-1 - WORD_BITS*int'(idx) -: WORD_BITS];
  endfunction

endpackage

`default_nettype wire

// File: rtl/chacha20_poly1305_tag_verify.sv
// ============================================================================
// Module   : chacha20_poly1305_tag_verify
// Purpose  : Decrypt-side Poly1305 tag checker. The host loads the received
//            tag word-serially; the core's computed tag is captured on
//            calc_tag_valid and the two are compared one 32-bit word per
//            cycle, always taking four cycles regardless of where (or if)
//            they differ.
// Ports    : clk, reset_n       clock / async active-low reset
//            clear              sync abort to IDLE (fail_cnt, rx tag kept)
//            rx_we/addr/data    received-tag word write
//            start              arm the verifier
//            calc_tag_valid/tag computed tag from the core
//            ready, done        status (ready in IDLE and DONE)
//            tag_correct        tags equal (valid while done)
//            release_ok         plaintext-release qualifier
//            fail_cnt           saturating authentication-failure count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chacha20_poly1305_tag_verify
  import chacha20_poly1305_pkg::*;
#(
  parameter int FAIL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  rx_we,
  input  logic [1:0]            rx_addr,
  input  logic [WORD_BITS-1:0]  rx_data,
  input  logic                  start,
  input  logic                  calc_tag_valid,
  input  logic [TAG_BITS-1:0]   calc_tag,
  output logic                  ready,
  output logic                  done,
  output logic                  tag_correct,
  output logic                  release_ok,
  output logic [FAIL_CNT_W-1:0] fail_cnt
);

  verify_state_t         r_state;
  verify_state_t         w_state_next;
  logic [TAG_BITS-1:0]   r_rx_tag;
  logic [TAG_BITS-1:0]   r_calc_reg;
  logic [WORD_BITS-1:0]  r_diff;
  logic [1:0]            r_word_ctr;
  logic [FAIL_CNT_W-1:0] r_fail_cnt;

  logic                  w_host_phase;   // IDLE or DONE: host may load / arm
  logic                  w_rx_write;
  logic                  w_arm;
  logic                  w_capture;
  logic                  w_last_word;
  logic [WORD_BITS-1:0]  w_diff_next;

  assign w_host_phase = (r_state == VS_IDLE) || (r_state == VS_DONE);
  // clear outranks every other input, so it also blocks tag writes
  assign w_rx_write   = rx_we & ~clear & w_host_phase;
  assign w_arm        = start & ~clear & w_host_phase;
  assign w_capture    = calc_tag_valid & ~clear & (r_state == VS_WAIT_TAG);
  assign w_last_word  = (r_word_ctr == 2'(TAG_WORDS-1));

  // OR-accumulate the XOR of each word pair; no data-dependent exit
  assign w_diff_next  = r_diff | (tag_word(r_rx_tag, r_word_ctr) ^
                                  tag_word(r_calc_reg, r_word_ctr));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= VS_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = VS_IDLE;
    end else begin
      case (r_state)
        VS_IDLE:     if (start)          w_state_next = VS_WAIT_TAG;
        VS_WAIT_TAG: if (calc_tag_valid) w_state_next = VS_COMPARE;
        VS_COMPARE:  if (w_last_word)    w_state_next = VS_DONE;
        VS_DONE:     if (start)          w_state_next = VS_WAIT_TAG;
        default:                         w_state_next = VS_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    ready       = w_host_phase;
    done        = (r_state == VS_DONE);
    tag_correct = (r_state == VS_DONE) && (r_diff == '0);
    release_ok  = (r_state == VS_DONE) && (r_diff == '0);
    fail_cnt    = r_fail_cnt;
  end

  // --------------------------------------------------------------------------
  // Tag storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_tag   <= '0;
      r_calc_reg <= '0;
    end else begin
      if (w_rx_write) begin
        r_rx_tag[TAG_BITS-1 - WORD_BITS*int'(rx_addr) -: WORD_BITS] <= rx_data;
      end
      if (w_capture) begin
        r_calc_reg <= calc_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Difference accumulator and word counter. The counter increments every
  // COMPARE cycle, so it wraps 3->0 exactly on the COMPARE->DONE edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_diff     <= '0;
      r_word_ctr <= '0;
    end else if (clear || w_arm) begin
      r_diff     <= '0;
      r_word_ctr <= '0;
    end else if (r_state == VS_COMPARE) begin
      r_diff     <= w_diff_next;
      r_word_ctr <= r_word_ctr + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Failure counter: bumped once on entry to DONE, saturating at all-ones
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fail_cnt <= '0;
    end else if (!clear && (r_state == VS_COMPARE) && w_last_word &&
                 (w_diff_next != '0) && (r_fail_cnt != '1)) begin
      r_fail_cnt <= r_fail_cnt + FAIL_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chacha20_poly1305_tag_verify.sv
// ============================================================================
// Module   : tb_chacha20_poly1305_tag_verify
// Purpose  : Directed self-checking bench for chacha20_poly1305_tag_verify
//            using the RFC 8439 2.8.2 Poly1305 tag and single-bit variants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chacha20_poly1305_tag_verify;

  localparam int FAIL_CNT_W = 8;
  localparam logic [127:0] C_GOOD   = 128'h1ae10b594f09e26a7e902ecbd0600691;
  localparam logic [127:0] C_BIT0   = 128'h1ae10b594f09e26a7e902ecbd0600690;
  localparam logic [127:0] C_BIT127 = 128'h9ae10b594f09e26a7e902ecbd0600691;

  logic                  clk;
  logic                  reset_n;
  logic                  clear;
  logic                  rx_we;
  logic [1:0]            rx_addr;
  logic [31:0]           rx_data;
  logic                  start;
  logic                  calc_tag_valid;
  logic [127:0]          calc_tag;
  logic                  ready;
  logic                  done;
  logic                  tag_correct;
  logic                  release_ok;
  logic [FAIL_CNT_W-1:0] fail_cnt;

  int n_cmp;
  int n_bad;
  int lat;

  chacha20_poly1305_tag_verify #(.FAIL_CNT_W(FAIL_CNT_W)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .rx_we          (rx_we),
    .rx_addr        (rx_addr),
    .rx_data        (rx_data),
    .start          (start),
    .calc_tag_valid (calc_tag_valid),
    .calc_tag       (calc_tag),
    .ready          (ready),
    .done           (done),
    .tag_correct    (tag_correct),
    .release_ok     (release_ok),
    .fail_cnt       (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_rx(input logic [127:0] t);
    for (int i = 0; i < 4; i++) begin
      rx_we   = 1'b1;
      rx_addr = 2'(i);
      rx_data = t[127-32*i -: 32];
      step();
    end
    rx_we = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present the computed tag for one cycle, then count edges until done (bounded)
  task automatic feed(input logic [127:0] c, output int n);
    calc_tag       = c;
    calc_tag_valid = 1'b1;
    step();
    calc_tag_valid = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    clear = 1'b0;
    rx_we = 1'b0;
    rx_addr = 2'd0;
    rx_data = 32'd0;
    start = 1'b0;
    calc_tag_valid = 1'b0;
    calc_tag = '0;
    step();
    step();

    // Reset state
    chk("rst_ready", 128'(ready), 128'd1);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_tag_correct", 128'(tag_correct), 128'd0);
    chk("rst_release", 128'(release_ok), 128'd0);
    chk("rst_fail_cnt", 128'(fail_cnt), 128'd0);
    reset_n = 1'b1;
    step();

    // RFC 8439 matching tag
    write_rx(C_GOOD);
    arm();
    chk("wait_ready", 128'(ready), 128'd0);
    feed(C_GOOD, lat);
    chk("good_latency", 128'(lat), 128'd4);
    chk("good_tag_correct", 128'(tag_correct), 128'd1);
    chk("good_release", 128'(release_ok), 128'd1);
    chk("good_fail_cnt", 128'(fail_cnt), 128'd0);
    chk("done_ready", 128'(ready), 128'd1);

    // Bit 0 flipped
    arm();
    feed(C_BIT0, lat);
    chk("bit0_latency", 128'(lat), 128'd4);
    chk("bit0_tag_correct", 128'(tag_correct), 128'd0);
    chk("bit0_release", 128'(release_ok), 128'd0);
    chk("bit0_fail_cnt", 128'(fail_cnt), 128'd1);

    // Bit 127 flipped: same latency; start during COMPARE is ignored
    arm();
    calc_tag       = C_BIT127;
    calc_tag_valid = 1'b1;
    step();
    calc_tag_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk("bit127_latency", 128'(lat), 128'd4);
    chk("bit127_tag_correct", 128'(tag_correct), 128'd0);
    chk("bit127_fail_cnt", 128'(fail_cnt), 128'd2);

    // done held until start
    step();
    step();
    chk("done_held", 128'(done), 128'd1);

    // clear in the 2nd COMPARE cycle
    arm();
    calc_tag       = C_BIT0;
    calc_tag_valid = 1'b1;
    step();
    calc_tag_valid = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_ready", 128'(ready), 128'd1);
    chk("clear_done", 128'(done), 128'd0);
    for (int i = 0; i < 6; i++) step();
    chk("clear_done_later", 128'(done), 128'd0);
    chk("clear_fail_cnt", 128'(fail_cnt), 128'd2);

    // calc_tag_valid in IDLE is ignored
    calc_tag       = C_GOOD;
    calc_tag_valid = 1'b1;
    step();
    calc_tag_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_calc_ready", 128'(ready), 128'd1);
    chk("idle_calc_done", 128'(done), 128'd0);

    // After clear: start + matching tags; rx writes in WAIT_TAG are ignored
    arm();
    rx_we = 1'b1; rx_addr = 2'd0; rx_data = 32'h0;
    step();
    rx_we = 1'b0;
    feed(C_GOOD, lat);
    chk("post_clear_latency", 128'(lat), 128'd4);
    chk("post_clear_tag_correct", 128'(tag_correct), 128'd1);

    // start and calc_tag_valid together in DONE/IDLE: only start acts
    start = 1'b1;
    calc_tag = C_GOOD;
    calc_tag_valid = 1'b1;
    step();
    start = 1'b0;
    calc_tag_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("start_calc_same_done", 128'(done), 128'd0);
    chk("start_calc_same_ready", 128'(ready), 128'd0);
    feed(C_GOOD, lat);
    chk("start_calc_then_tag", 128'(tag_correct), 128'd1);

    // rx_we with start in the same cycle: the new word is compared
    rx_we = 1'b1; rx_addr = 2'd3; rx_data = 32'hd0600690;
    start = 1'b1;
    step();
    rx_we = 1'b0;
    start = 1'b0;
    feed(C_BIT0, lat);
    chk("we_start_tag_correct", 128'(tag_correct), 128'd1);
    chk("we_start_fail_cnt", 128'(fail_cnt), 128'd2);

    // Async reset mid-COMPARE
    arm();
    calc_tag       = C_GOOD;
    calc_tag_valid = 1'b1;
    step();
    calc_tag_valid = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_ready", 128'(ready), 128'd1);
    chk("areset_done", 128'(done), 128'd0);
    chk("areset_fail_cnt", 128'(fail_cnt), 128'd0);
    reset_n = 1'b1;
    step();
    // rx_tag reset to zero: zero calc tag must match
    arm();
    feed(128'd0, lat);
    chk("areset_rx_zero", 128'(tag_correct), 128'd1);

    // Saturation: 300 mismatches against zero rx tag
    for (int i = 0; i < 300; i++) begin
      arm();
      feed(128'd1, lat);
      if (i == 9) chk("sat_cnt_10", 128'(fail_cnt), 128'd10);
    end
    chk("sat_fail_cnt", 128'(fail_cnt), 128'd255);
    chk("sat_tag_correct", 128'(tag_correct), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
